// File: rtl/seg_disp_sched.sv
// Round-robin time-share scheduler for the 4-digit 7-segment display.
// One requester owns the display for a fixed dwell, then a one-cycle gap separates owners.
module seg_disp_sched #(
    parameter int N_REQ       = 4,
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int CW          = $clog2(HOLD_CYCLES + 1)
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic [N_REQ-1:0]     req,
    input  logic [16*N_REQ-1:0]  data,
    output logic [N_REQ-1:0]     gnt,
    output logic [2:0]           owner,
    output logic                 active,
    output logic [15:0]          x,
    output logic                 rel
);

    typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [2:0]         owner_q, owner_d;
    logic [2:0]         last_q, last_d;
    logic               active_q, active_d;
    logic [15:0]        x_q, x_d;
    logic               rel_q, rel_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    logic [7:0]         req_ext;
    logic [15:0]        data_arr [8];
    logic               win_found;
    logic [2:0]         win_idx;

    // Pad requests and data to 8 entries so a 3-bit index never selects out of range.
    assign req_ext = 8'(req);

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_data
            if (gi < N_REQ) begin : g_used
                assign data_arr[gi] = data[16*gi +: 16];
            end else begin : g_pad
                assign data_arr[gi] = 16'h0000;
            end
        end
    endgenerate

    // Scan downward in distance so the nearest set bit after last_q is assigned last and wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = 3'd0;
        for (int k = N_REQ; k >= 1; k--) begin
            if (req_ext[3'((int'(last_q) + k) % N_REQ)]) begin
                win_found = 1'b1;
                win_idx   = 3'((int'(last_q) + k) % N_REQ);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        owner_d  = owner_q;
        last_d   = last_q;
        active_d = active_q;
        x_d      = x_q;
        rel_d    = 1'b0;
        cnt_d    = cnt_q;
        case (state_q)
            HOLD: begin
                if (cnt_q == '0 || !req_ext[owner_q]) begin
                    state_d  = GAP;
                    gnt_d    = '0;
                    active_d = 1'b0;
                    x_d      = 16'h0000;
                    rel_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                    x_d   = data_arr[owner_q];
                end
            end
            default: begin
                // IDLE and GAP both arbitrate; the display stays blank unless someone wins.
                gnt_d    = '0;
                active_d = 1'b0;
                x_d      = 16'h0000;
                state_d  = IDLE;
                if (win_found) begin
                    state_d  = HOLD;
                    gnt_d    = N_REQ'(1) << win_idx;
                    owner_d  = win_idx;
                    last_d   = win_idx;
                    active_d = 1'b1;
                    x_d      = data_arr[win_idx];
                    cnt_d    = CW'(HOLD_CYCLES - 1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            owner_q  <= 3'd0;
            last_q   <= 3'(N_REQ - 1);
            active_q <= 1'b0;
            x_q      <= 16'h0000;
            rel_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            active_q <= active_d;
            x_q      <= x_d;
            rel_q    <= rel_d;
            cnt_q    <= cnt_d;
        end
    end

    assign gnt    = gnt_q;
    assign owner  = owner_q;
    assign active = active_q;
    assign x      = x_q;
    assign rel    = rel_q;

endmodule

// File: tb/tb_seg_disp_sched.sv
// Randomized and directed bench for seg_disp_sched against a cycle-level behavioural model.
module tb_seg_disp_sched;

    localparam int N    = 4;
    localparam int HOLD = 4;

    logic          clk = 1'b0;
    logic          clr = 1'b1;
    logic [N-1:0]  req = '0;
    logic [15:0]   dv [N];
    logic [16*N-1:0] data;
    logic [N-1:0]  gnt;
    logic [2:0]    owner;
    logic          active;
    logic [15:0]   x;
    logic          rel;

    int n_vec = 0;
    int n_err = 0;

    assign data = {dv[3], dv[2], dv[1], dv[0]};

    seg_disp_sched #(.N_REQ(N), .HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .clr(clr), .req(req), .data(data),
        .gnt(gnt), .owner(owner), .active(active), .x(x), .rel(rel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: 0 = nobody owns, 1 = owned, 2 = gap cycle after a grant.
    int          m_state = 0;
    int          m_own = 0;
    int          m_last = N - 1;
    int          m_elapsed = 0;
    int          m_w;
    logic [15:0] m_x = 16'h0000;
    logic [N-1:0] e_gnt;

    always @(posedge clk or posedge clr) begin
        if (clr) begin
            m_state = 0;
            m_own   = 0;
            m_last  = N - 1;
            m_x     = 16'h0000;
        end else if (m_state == 1) begin
            m_elapsed++;
            if (m_elapsed >= HOLD || !req[m_own]) m_state = 2;
            else m_x = dv[m_own];
        end else begin
            m_w = -1;
            for (int k = 1; k <= N; k++)
                if (m_w < 0 && req[(m_last + k) % N]) m_w = (m_last + k) % N;
            if (m_w >= 0) begin
                m_state   = 1;
                m_own     = m_w;
                m_last    = m_w;
                m_elapsed = 0;
                m_x       = dv[m_w];
                $display("grant owner=%0d x=%h t=%0t", m_w, dv[m_w], $time);
            end else begin
                m_state = 0;
            end
        end
        #1;
        e_gnt = (m_state == 1) ? N'(1 << m_own) : '0;
        chk("gnt", 32'(gnt), 32'(e_gnt));
        chk("active", 32'(active), 32'(m_state == 1));
        chk("x", 32'(x), 32'((m_state == 1) ? m_x : 16'h0000));
        chk("rel", 32'(rel), 32'(m_state == 2));
        if (m_state == 1) chk("owner", 32'(owner), 32'(m_own));
    end

    task automatic do_reset();
        @(negedge clk);
        clr = 1'b1;
        req = '0;
        repeat (2) @(negedge clk);
        clr = 1'b0;
    endtask

    int          nrel;
    int          bad;
    logic        prev_act;
    logic [N-1:0] eg;
    logic [15:0] ex;
    int          grants [$];

    initial begin
        for (int i = 0; i < N; i++) dv[i] = 16'h0000;
        repeat (2) @(negedge clk);
        chk("reset_gnt", 32'(gnt), 32'h0);
        chk("reset_x", 32'(x), 32'h0);
        chk("reset_owner", 32'(owner), 32'h0);

        // Rotation
        do_reset();
        for (int i = 0; i < N; i++) dv[i] = 16'h1111 * 16'(i);
        req  = 4'b1111;
        nrel = 0;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk); #2;
            eg = (c % 5 == 4) ? 4'b0000 : 4'(1 << ((c / 5) % 4));
            ex = (c % 5 == 4) ? 16'h0000 : 16'h1111 * 16'((c / 5) % 4);
            chk("rot_gnt", 32'(gnt), 32'(eg));
            chk("rot_x", 32'(x), 32'(ex));
            if (rel) nrel++;
        end
        chk("rot_rel_count", 32'(nrel), 32'd5);

        // Asynchronous clear mid-hold, then restart from requester 0
        @(posedge clk); #2;
        chk("pre_clr_active", 32'(active), 32'h1);
        @(negedge clk);
        clr = 1'b1;
        #1;
        chk("clr_gnt", 32'(gnt), 32'h0);
        chk("clr_x", 32'(x), 32'h0);
        chk("clr_active", 32'(active), 32'h0);
        @(negedge clk);
        clr = 1'b0;
        @(posedge clk); #2;
        chk("clr_first_gnt", 32'(gnt), 32'b0001);

        // Skip idle requesters
        do_reset();
        req = 4'b1010;
        grants.delete();
        bad = 0;
        prev_act = 1'b0;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk); #2;
            if (active && !prev_act) grants.push_back(int'(owner));
            if (gnt[0] || gnt[2]) bad++;
            prev_act = active;
        end
        chk("skip_count", 32'(grants.size() >= 4), 32'h1);
        if (grants.size() >= 4) begin
            chk("skip_g0", 32'(grants[0]), 32'd1);
            chk("skip_g1", 32'(grants[1]), 32'd3);
            chk("skip_g2", 32'(grants[2]), 32'd1);
            chk("skip_g3", 32'(grants[3]), 32'd3);
        end
        chk("skip_never_0_2", 32'(bad), 32'd0);

        // Early release in the second hold cycle
        do_reset();
        req = 4'b0100;
        @(posedge clk); #2;
        chk("er_hold1", 32'(gnt), 32'b0100);
        @(posedge clk); #2;
        chk("er_hold2", 32'(gnt), 32'b0100);
        @(negedge clk);
        req = 4'b1000;
        @(posedge clk); #2;
        chk("er_gap_rel", 32'(rel), 32'h1);
        chk("er_gap_gnt", 32'(gnt), 32'h0);
        @(posedge clk); #2;
        chk("er_next_gnt", 32'(gnt), 32'b1000);
        @(negedge clk);
        req = 4'b0000;
        @(posedge clk); #2;
        chk("er_rel2", 32'(rel), 32'h1);
        @(posedge clk); #2;
        chk("er_idle", 32'(active), 32'h0);

        // Live tracking of the owner's data only
        do_reset();
        dv[0] = 16'h1234;
        req = 4'b0001;
        @(posedge clk); #2;
        chk("live_x0", 32'(x), 32'h1234);
        @(negedge clk);
        dv[1] = 16'hFFFF;
        @(posedge clk); #2;
        chk("live_nonowner", 32'(x), 32'h1234);
        @(negedge clk);
        dv[0] = 16'hBEEF;
        @(posedge clk); #2;
        chk("live_beef", 32'(x), 32'hBEEF);

        // Sole requester re-granted after every gap
        do_reset();
        dv[2] = 16'hA5A5;
        req = 4'b0100;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #2;
            eg = (c % 5 == 4) ? 4'b0000 : 4'b0100;
            chk("sole_gnt", 32'(gnt), 32'(eg));
            chk("sole_x", 32'(x), 32'((c % 5 == 4) ? 16'h0000 : 16'hA5A5));
        end

        // Random traffic with occasional asynchronous clears
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) req = N'($urandom);
            for (int i = 0; i < N; i++) dv[i] = 16'($urandom);
            clr = ($urandom_range(0, 199) == 0);
        end
        @(negedge clk);
        clr = 1'b0;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/seg_disp_sched.md
# seg_disp_sched

Time-share scheduler for the 4-digit 7-segment display. Up to N_REQ requesters each present a 16-bit hex value. The block grants the display to one requester at a time in round-robin order, holds the grant for a programmable dwell time, and drives the selected value to the display driver's 16-bit `x` input. It sits between the application datapaths and the display driver, which owns digit multiplexing and segment decode.

## Interface

Parameters:
- `N_REQ`, default 4: number of requesters, range 2..8.
- `HOLD_CYCLES`, default 50_000_000: dwell time per grant in clk cycles, must be ≥ 1.
- `CW`, default `$clog2(HOLD_CYCLES+1)`: dwell counter width.

Ports:
- `clk`, in, 1: clock.
- `clr`, in, 1: reset. Asynchronous, active-high.
- `req`, in, N_REQ: per-requester request level. Held high while the requester wants display time.
- `data`, in, 16*N_REQ: requester i value on `data[16*i+15:16*i]`.
- `gnt`, out, N_REQ: one-hot grant. All zero when no owner.
- `owner`, out, 3: index of the current owner. Valid only while `active`=1.
- `active`, out, 1: display currently owned.
- `x`, out, 16: value to the display driver.
- `rel`, out, 1: one-cycle pulse on the cycle after a grant ends.

## Operation

- All outputs are registered.
- Reset values: `gnt`=0, `owner`=0, `active`=0, `x`=16'h0000, `rel`=0, state=IDLE, `last`=N_REQ-1, counter=0.
- States: IDLE, HOLD, GAP.
- **IDLE:**
  - `x`=0, `active`=0.
  - If `req`≠0, arbitrate, then go to HOLD.
- **Arbitration (round-robin):**
  - Winner is the first set bit of `req`, scanning from index (`last`+1) mod N_REQ upward with wrap.
  - From reset, `req[0]` has first priority.
- **Entering HOLD with winner w:**
  - `gnt`=1<<w, `owner`=w, `active`=1, `x`=`data[w]`.
  - Counter loads HOLD_CYCLES-1; `last`=w.
- **HOLD:**
  - `x` tracks `data[owner]` live, registered, one cycle latency.
  - Counter decrements by 1 per cycle and never underflows.
  - Exit to GAP when counter==0, or when `req[owner]`=0 (early release); whichever comes first.
- **GAP:** lasts exactly one cycle.
  - `gnt`=0, `active`=0, `x`=0, `rel`=1.
  - `req` is sampled here. If `req`≠0, arbitrate and go to HOLD. Otherwise go to IDLE.
- Requests from non-owners during HOLD are ignored; there is no preemption. Those requesters wait their round-robin turn.
- A sole requester that stays asserted is re-granted after every GAP.
- A `req` pulse shorter than one cycle that is not sampled in IDLE or GAP is lost. This is not an error.
- `data` of non-owners is don't-care.
- `clr` mid-HOLD: all outputs go to reset values immediately and asynchronously. Round-robin history is lost.

## Timing

- Request latency: `req` first sampled high at edge T in IDLE gives `gnt`/`active`/`x` valid after edge T, i.e. visible in cycle T+1.
- Dwell: with `req[owner]` held, `gnt` is high for exactly HOLD_CYCLES cycles, followed by 1 GAP cycle.
- Owner-to-owner period is HOLD_CYCLES+1 cycles.
- Early release: `req[owner]` sampled low at edge E. GAP/`rel` occupy cycle E+1, and `gnt` is low from E+1.
- HOLD_CYCLES=1: each grant lasts 1 cycle, then GAP, alternating.
- `x` is never driven from two owners. The GAP cycle guarantees at least one cycle of `gnt`=0 between owners.

## Test plan

- **Reset:** assert `clr` mid-HOLD (HOLD_CYCLES=4).
  - Expect `gnt`=0, `x`=0, `active`=0 asynchronously.
  - After release with `req`=4'b1111, first grant goes to 0.
- **Rotation:** HOLD_CYCLES=4, `req`=4'b1111 constant, `data`=16'h0000/1111/2222/3333.
  - Expect `gnt` sequence 0001, 0010, 0100, 1000, 0001, each exactly 4 cycles with 1 GAP cycle between.
  - Expect `x` matching each owner's data and one `rel` pulse per grant.
- **Skip:** `req`=4'b1010 with `last`=1.
  - Expect grant to 3, then 1, then 3.
  - Indices 0 and 2 are never granted.
- **Early release:** owner 2 drops `req` in the 2nd HOLD cycle.
  - Expect GAP on the next cycle, `rel`=1, then grant to the next pending requester or IDLE.
- **Live tracking:** owner 0 changes `data[0]` from 16'h1234 to 16'hBEEF mid-HOLD.
  - Expect `x`=16'hBEEF one cycle later.
  - A change to non-owner `data` has no effect on `x`.
- **Sole requester:** `req`=4'b0100 constant.
  - Expect `gnt`=0100 for HOLD_CYCLES cycles, 1 GAP cycle with `x`=0, then re-grant. Repeats indefinitely.
